// File: rtl/iiitb_nbit_rc.sv
// Parametrised ring / Johnson counter with run-time mode and direction,
// parallel load, wrap pulse and illegal-state detection with optional
// self-correction back to RESET_VAL.
module iiitb_nbit_rc #(
  parameter int unsigned           WIDTH       = 3,
  parameter logic [WIDTH-1:0]      RESET_VAL   = {1'b1, {(WIDTH-1){1'b0}}},
  parameter bit                    AUTOCORRECT = 1'b1
) (
  input  logic             clk,
  input  logic             ori,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             illegal
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] stepped;
  int unsigned      ones;
  int unsigned      edges;

  // Legality of the current state under the current mode: ring needs exactly
  // one set bit, Johnson allows at most one boundary between adjacent bits.
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {31'b0, count_q[i]};
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + {31'b0, count_q[i] ^ count_q[i+1]};
    end
    illegal = mode ? (edges > 1) : (ones != 1);
  end

  // One shift of the current state; Johnson feeds back the inverted end bit.
  always_comb begin
    stepped = count_q;
    unique case ({mode, dir})
      2'b00: stepped = {count_q[0], count_q[WIDTH-1:1]};
      2'b01: stepped = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      2'b10: stepped = {~count_q[0], count_q[WIDTH-1:1]};
      2'b11: stepped = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      default: stepped = count_q;
    endcase
  end

  // Next-state selection: load beats step; a corrective jump never wraps.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (AUTOCORRECT && illegal) begin
        count_d = RESET_VAL;
      end else begin
        count_d = stepped;
        wrap_d  = (stepped == RESET_VAL);
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (ori) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_iiitb_nbit_rc.sv
// Randomized and directed bench for iiitb_nbit_rc. Three instances share the
// control inputs: WIDTH=3 with correction, WIDTH=4 with correction, and
// WIDTH=3 without correction. A behavioural model tracks each one.
module tb_iiitb_nbit_rc;

  logic       clk;
  logic       ori, en, dir, mode, load;
  logic [2:0] lv3, lvn;
  logic [3:0] lv4;
  logic [2:0] c3, cn;
  logic [3:0] c4;
  logic       w3, w4, wn;
  logic       i3, i4, in_;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state per instance.
  int m3, m4, mn;
  bit mw3, mw4, mwn;

  iiitb_nbit_rc #(.WIDTH(3), .AUTOCORRECT(1'b1)) dut3 (
    .clk(clk), .ori(ori), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv3), .count(c3), .wrap(w3), .illegal(i3)
  );

  iiitb_nbit_rc #(.WIDTH(4), .AUTOCORRECT(1'b1)) dut4 (
    .clk(clk), .ori(ori), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv4), .count(c4), .wrap(w4), .illegal(i4)
  );

  iiitb_nbit_rc #(.WIDTH(3), .AUTOCORRECT(1'b0)) dutn (
    .clk(clk), .ori(ori), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lvn), .count(cn), .wrap(wn), .illegal(in_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Ring: a single set bit. Johnson: some run of low ones, or its complement.
  function automatic bit legal(input int w, input bit md, input int q);
    int mask = (1 << w) - 1;
    if (!md) return (q != 0) && ((q & (q - 1)) == 0);
    for (int k = 0; k <= w; k++) begin
      if (q == ((1 << k) - 1) || q == (mask ^ ((1 << k) - 1))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int shift(input int w, input bit md, input bit dr, input int q);
    int mask = (1 << w) - 1;
    int msb  = (q >> (w - 1)) & 1;
    int lsb  = q & 1;
    if (md) begin
      msb = msb ^ 1;
      lsb = lsb ^ 1;
    end
    if (dr) return ((q << 1) & mask) | msb;
    else    return (q >> 1) | (lsb << (w - 1));
  endfunction

  function automatic void model_next(input int w, input bit ac, input int q, input int lv,
                                     output int qn, output bit wn_o);
    int rv = 1 << (w - 1);
    qn   = q;
    wn_o = 1'b0;
    if (ori) qn = rv;
    else if (load) qn = lv;
    else if (en) begin
      if (ac && !legal(w, mode, q)) qn = rv;
      else begin
        qn   = shift(w, mode, dir, q);
        wn_o = (qn == rv);
      end
    end
  endfunction

  // Advance one clock with the inputs currently driven, then compare all
  // outputs against the model on the falling edge.
  task automatic cycle();
    int q3, q4, qn;
    bit x3, x4, xn;
    model_next(3, 1'b1, m3, int'(lv3), q3, x3);
    model_next(4, 1'b1, m4, int'(lv4), q4, x4);
    model_next(3, 1'b0, mn, int'(lvn), qn, xn);
    @(posedge clk);
    m3 = q3; m4 = q4; mn = qn;
    mw3 = x3; mw4 = x4; mwn = xn;
    @(negedge clk);
    check("count3", int'(c3), m3);
    check("wrap3", int'(w3), int'(mw3));
    check("illegal3", int'(i3), int'(!legal(3, mode, m3)));
    check("count4", int'(c4), m4);
    check("wrap4", int'(w4), int'(mw4));
    check("illegal4", int'(i4), int'(!legal(4, mode, m4)));
    check("countn", int'(cn), mn);
    check("wrapn", int'(wn), int'(mwn));
    check("illegaln", int'(in_), int'(!legal(3, mode, mn)));
  endtask

  task automatic idle();
    ori = 1'b0; en = 1'b0; load = 1'b0;
  endtask

  initial begin
    int jl4 [8] = '{0, 1, 3, 7, 15, 14, 12, 8};
    int rr3 [3] = '{2, 1, 4};
    int nc3 [3] = '{5, 6, 3};

    m3 = 4; m4 = 8; mn = 4;
    ori = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0;
    lv3 = '0; lv4 = '0; lvn = '0;
    @(negedge clk);
    cycle();
    cycle();
    check("reset_count3", int'(c3), 4);
    check("reset_wrap3", int'(w3), 0);
    check("reset_illegal3", int'(i3), 0);

    // Ring right, WIDTH=3.
    idle(); en = 1'b1; dir = 1'b0; mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("ring_r_seq", int'(c3), rr3[i]);
      check("ring_r_wrap", int'(w3), (i == 2) ? 1 : 0);
    end

    // Johnson left, WIDTH=4, from reset.
    idle(); ori = 1'b1; cycle();
    idle(); en = 1'b1; mode = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check("john_l_seq", int'(c4), jl4[i]);
      check("john_l_wrap", int'(w4), (i == 7) ? 1 : 0);
    end

    // Priority: load over enable, then reset over load.
    idle(); mode = 1'b0; load = 1'b1; en = 1'b1; lv3 = 3'b010;
    cycle();
    check("prio_load", int'(c3), 2);
    ori = 1'b1; cycle();
    check("prio_reset", int'(c3), 4);

    // Autocorrect vs no correction, ring mode, illegal 011 loaded.
    idle(); load = 1'b1; lv3 = 3'b011; lvn = 3'b011; dir = 1'b0;
    cycle();
    check("ac_illegal", int'(i3), 1);
    idle(); en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (i == 0) begin
        check("ac_count", int'(c3), 4);
        check("ac_wrap", int'(w3), 0);
        check("ac_legal", int'(i3), 0);
      end
      check("nc_seq", int'(cn), nc3[i]);
      check("nc_illegal", int'(in_), 1);
    end

    // Live mode switch from Johnson 110 to ring, then hold.
    idle(); ori = 1'b1; cycle();
    idle(); en = 1'b1; mode = 1'b1; dir = 1'b0;
    cycle();
    check("sw_johnson", int'(c3), 6);
    mode = 1'b0;
    #1;
    check("sw_illegal", int'(i3), 1);
    cycle();
    check("sw_fix", int'(c3), 4);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_count", int'(c3), 4);
      check("hold_wrap", int'(w3), 0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ori  = ($urandom_range(0, 99) < 3);
      load = ($urandom_range(0, 99) < 6);
      en   = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 10) dir = ~dir;
      if ($urandom_range(0, 99) < 10) mode = ~mode;
      lv3 = 3'($urandom);
      lv4 = 4'($urandom);
      lvn = 3'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
